branch_scheduler: RTL and testbench

- Reservation station and sequencer for the combinational branch execution unit.
- Holds up to DEPTH branch/jump ops until their operands are resolved by snooping the common result bus, then issues the oldest ready op to the branch unit.
- Registers the unit's outputs, arbitrates for the result bus, and raises a redirect on target misprediction.
- Sits between the issue stage and the branch unit, beside the ALU/LSU stations.

---
 rtl/branch_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_branch_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_scheduler.sv
// Reservation station for the branch unit: holds ops until their operands resolve off the
// result bus, issues the oldest ready op, registers the result and flags mispredictions.
module branch_scheduler #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_address,
  input  logic [XLEN-1:0]  in_immediate,
  input  logic [XLEN-1:0]  in_data_1,
  input  logic [XLEN-1:0]  in_data_2,
  input  logic             in_rdy_1,
  input  logic             in_rdy_2,
  input  logic [TAG_W-1:0] in_tag_1,
  input  logic [TAG_W-1:0] in_tag_2,
  input  logic [TAG_W-1:0] in_dst_tag,
  input  logic [XLEN-1:0]  in_pred_target,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic [2:0]       ex_op,
  output logic [XLEN-1:0]  ex_address,
  output logic [XLEN-1:0]  ex_immediate,
  output logic [XLEN-1:0]  ex_data_1,
  output logic [XLEN-1:0]  ex_data_2,
  input  logic [XLEN-1:0]  ex_jump_result,
  input  logic [XLEN-1:0]  ex_store_result,
  output logic             rb_req,
  input  logic             rb_grant,
  output logic [TAG_W-1:0] rb_tag,
  output logic [XLEN-1:0]  rb_data,
  output logic             rb_writes,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_address
);
  localparam int IW = $clog2(DEPTH);
  localparam int AW = IW + 1;

  logic [DEPTH-1:0] e_vld, e_r1, e_r2, snoop1, snoop2;
  logic [2:0]       e_op   [DEPTH];
  logic [XLEN-1:0]  e_pc   [DEPTH];
  logic [XLEN-1:0]  e_imm  [DEPTH];
  logic [XLEN-1:0]  e_d1   [DEPTH];
  logic [XLEN-1:0]  e_d2   [DEPTH];
  logic [XLEN-1:0]  e_pred [DEPTH];
  logic [TAG_W-1:0] e_t1   [DEPTH];
  logic [TAG_W-1:0] e_t2   [DEPTH];
  logic [TAG_W-1:0] e_dst  [DEPTH];
  logic [AW-1:0]    e_age  [DEPTH];
  logic [AW-1:0]    alloc_cnt;

  logic             slot_full_p1, slot_writes_p1;
  logic [TAG_W-1:0] slot_tag_p1;
  logic [XLEN-1:0]  slot_data_p1, slot_jump_p1, slot_pred_p1;
  logic             redirect_p2;
  logic [XLEN-1:0]  redirect_addr_p2;

  logic             free_any, sel_any;
  logic [IW-1:0]    free_idx, sel_idx;
  logic [AW-1:0]    best_dist;
  logic             slot_grant, mispredict, sel_en, issue, alloc;
  logic             snoop1_in, snoop2_in;

  // Allocations since the stamp was taken; the counter is one bit wider than the index,
  // so live entries always sit within DEPTH of it even after wrap-around.
  function automatic logic [AW-1:0] age_dist(input logic [AW-1:0] cnt, input logic [AW-1:0] stamp);
    return cnt - stamp;
  endfunction

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!e_vld[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    sel_any   = 1'b0;
    sel_idx   = '0;
    best_dist = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (e_vld[i] && e_r1[i] && e_r2[i] &&
          (!sel_any || age_dist(alloc_cnt, e_age[i]) > best_dist)) begin
        sel_any   = 1'b1;
        sel_idx   = IW'(i);
        best_dist = age_dist(alloc_cnt, e_age[i]);
      end
    end
  end

  always_comb begin
    snoop1 = '0;
    snoop2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      snoop1[i] = e_vld[i] & ~e_r1[i] & cdb_valid & (cdb_tag == e_t1[i]);
      snoop2[i] = e_vld[i] & ~e_r2[i] & cdb_valid & (cdb_tag == e_t2[i]);
    end
  end

  assign snoop1_in  = ~in_rdy_1 & cdb_valid & (cdb_tag == in_tag_1);
  assign snoop2_in  = ~in_rdy_2 & cdb_valid & (cdb_tag == in_tag_2);
  assign slot_grant = slot_full_p1 & rb_grant & ~flush_in;
  assign mispredict = slot_grant & (slot_jump_p1 != slot_pred_p1);
  assign sel_en     = ~slot_full_p1 | slot_grant;
  assign issue      = sel_any & sel_en & ~flush_in & ~mispredict;
  assign alloc      = in_valid & free_any & ~flush_in & ~mispredict;
  assign in_ready   = free_any;

  always_comb begin
    ex_op        = '0;
    ex_address   = '0;
    ex_immediate = '0;
    ex_data_1    = '0;
    ex_data_2    = '0;
    if (sel_any && sel_en) begin
      ex_op        = e_op[sel_idx];
      ex_address   = e_pc[sel_idx];
      ex_immediate = e_imm[sel_idx];
      ex_data_1    = e_d1[sel_idx];
      ex_data_2    = e_d2[sel_idx];
    end
  end

  // p0 -> p1: entry bookkeeping and output slot capture
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      e_vld            <= '0;
      e_r1             <= '0;
      e_r2             <= '0;
      alloc_cnt        <= '0;
      slot_full_p1     <= 1'b0;
      slot_writes_p1   <= 1'b0;
      slot_tag_p1      <= '0;
      slot_data_p1     <= '0;
      slot_jump_p1     <= '0;
      slot_pred_p1     <= '0;
      redirect_p2      <= 1'b0;
      redirect_addr_p2 <= '0;
    end else begin
      redirect_p2 <= mispredict;
      if (mispredict) redirect_addr_p2 <= slot_jump_p1;
      e_r1 <= e_r1 | snoop1;
      e_r2 <= e_r2 | snoop2;
      if (alloc) begin
        e_vld[free_idx] <= 1'b1;
        e_r1[free_idx]  <= in_rdy_1 | snoop1_in;
        e_r2[free_idx]  <= in_rdy_2 | snoop2_in;
        alloc_cnt       <= alloc_cnt + AW'(1);
      end
      if (issue) begin
        e_vld[sel_idx] <= 1'b0;
        slot_full_p1   <= 1'b1;
        slot_writes_p1 <= (e_op[sel_idx] < 3'd2);
        slot_tag_p1    <= e_dst[sel_idx];
        slot_data_p1   <= (e_op[sel_idx] < 3'd2) ? ex_store_result : '0;
        slot_jump_p1   <= ex_jump_result;
        slot_pred_p1   <= e_pred[sel_idx];
      end else if (slot_grant) begin
        slot_full_p1 <= 1'b0;
      end
      if (flush_in || mispredict) begin
        e_vld        <= '0;
        slot_full_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (snoop1[i]) e_d1[i] <= cdb_data;
      if (snoop2[i]) e_d2[i] <= cdb_data;
    end
    if (alloc) begin
      e_op[free_idx]   <= in_op;
      e_pc[free_idx]   <= in_address;
      e_imm[free_idx]  <= in_immediate;
      e_d1[free_idx]   <= snoop1_in ? cdb_data : in_data_1;
      e_d2[free_idx]   <= snoop2_in ? cdb_data : in_data_2;
      e_t1[free_idx]   <= in_tag_1;
      e_t2[free_idx]   <= in_tag_2;
      e_dst[free_idx]  <= in_dst_tag;
      e_pred[free_idx] <= in_pred_target;
      e_age[free_idx]  <= alloc_cnt;
    end
  end

  assign rb_req           = slot_full_p1;
  assign rb_tag           = slot_tag_p1;
  assign rb_data          = slot_data_p1;
  assign rb_writes        = slot_writes_p1;
  assign redirect         = redirect_p2;
  assign redirect_address = redirect_addr_p2;
endmodule

// File: tb/tb_branch_scheduler.sv
// Scoreboard bench for branch_scheduler: a queue-based station model predicts issue order,
// result-bus payloads and redirects; a negedge monitor compares against the DUT.
module tb_branch_scheduler;
  localparam int XLEN = 32, DEPTH = 4, TAG_W = 6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n, flush_in, in_valid, in_ready;
  logic [2:0] in_op;
  logic [31:0] in_address, in_immediate, in_data_1, in_data_2, in_pred_target;
  logic in_rdy_1, in_rdy_2;
  logic [5:0] in_tag_1, in_tag_2, in_dst_tag;
  logic cdb_valid;
  logic [5:0] cdb_tag;
  logic [31:0] cdb_data;
  logic [2:0] ex_op;
  logic [31:0] ex_address, ex_immediate, ex_data_1, ex_data_2, ex_jump_result, ex_store_result;
  logic rb_req, rb_grant, rb_writes, redirect;
  logic [5:0] rb_tag;
  logic [31:0] rb_data, redirect_address;

  branch_scheduler #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_address(in_address), .in_immediate(in_immediate),
    .in_data_1(in_data_1), .in_data_2(in_data_2),
    .in_rdy_1(in_rdy_1), .in_rdy_2(in_rdy_2),
    .in_tag_1(in_tag_1), .in_tag_2(in_tag_2), .in_dst_tag(in_dst_tag),
    .in_pred_target(in_pred_target),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_op(ex_op), .ex_address(ex_address), .ex_immediate(ex_immediate),
    .ex_data_1(ex_data_1), .ex_data_2(ex_data_2),
    .ex_jump_result(ex_jump_result), .ex_store_result(ex_store_result),
    .rb_req(rb_req), .rb_grant(rb_grant), .rb_tag(rb_tag), .rb_data(rb_data),
    .rb_writes(rb_writes), .redirect(redirect), .redirect_address(redirect_address)
  );

  // Behaviour of the external branch unit
  function automatic logic [31:0] bu_next(input logic [2:0] op, input logic [31:0] pc, imm, a, b);
    logic t;
    logic [31:0] nx;
    case (op)
      3'd2:    t = (a == b);
      3'd3:    t = (a != b);
      3'd4:    t = ($signed(a) < $signed(b));
      3'd5:    t = ($signed(a) >= $signed(b));
      3'd6:    t = (a < b);
      3'd7:    t = (a >= b);
      default: t = 1'b1;
    endcase
    nx = t ? pc + imm : pc + 32'd4;
    if (op == 3'd1) nx = (a + imm) & 32'hFFFF_FFFE;
    return nx;
  endfunction

  always_comb begin
    ex_jump_result  = bu_next(ex_op, ex_address, ex_immediate, ex_data_1, ex_data_2);
    ex_store_result = ex_address + 32'd4;
  end

  typedef struct {
    logic [2:0] op;
    logic [31:0] pc, imm, d1, d2, pred;
    bit r1, r2;
    logic [5:0] t1, t2, dst;
  } ent_t;
  typedef struct {
    logic [5:0] tag;
    logic [31:0] data, jump, pred;
    bit writes;
  } res_t;

  ent_t stq[$];
  res_t sb[$];
  res_t m_slot, mon_r;
  bit m_full = 0, m_redirect = 0, mon_en = 0;
  logic [31:0] m_raddr = '0;
  int chk_cnt = 0, pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Station model: ops kept in arrival order, so the oldest ready op is the first ready one.
  task automatic model_step();
    int pick, occ;
    bit granted, mis;
    ent_t e;
    res_t r;
    m_redirect = 0;
    if (!reset_n || flush_in) begin
      stq.delete();
      sb.delete();
      m_full = 0;
      return;
    end
    occ = stq.size();
    granted = m_full && rb_grant;
    mis = granted && (m_slot.jump != m_slot.pred);
    if (mis) begin
      stq.delete();
      m_full = 0;
      m_redirect = 1;
      m_raddr = m_slot.jump;
      return;
    end
    pick = -1;
    if (!m_full || granted) begin
      for (int i = 0; i < stq.size(); i++) begin
        if (stq[i].r1 && stq[i].r2) begin
          pick = i;
          break;
        end
      end
    end
    if (granted) m_full = 0;
    if (pick >= 0) begin
      e = stq[pick];
      stq.delete(pick);
      r.tag = e.dst;
      r.writes = (e.op < 3'd2);
      r.data = r.writes ? e.pc + 32'd4 : 32'd0;
      r.jump = bu_next(e.op, e.pc, e.imm, e.d1, e.d2);
      r.pred = e.pred;
      m_slot = r;
      m_full = 1;
      sb.push_back(r);
    end
    for (int i = 0; i < stq.size(); i++) begin
      if (cdb_valid && !stq[i].r1 && stq[i].t1 == cdb_tag) begin stq[i].r1 = 1; stq[i].d1 = cdb_data; end
      if (cdb_valid && !stq[i].r2 && stq[i].t2 == cdb_tag) begin stq[i].r2 = 1; stq[i].d2 = cdb_data; end
    end
    if (in_valid && occ < DEPTH) begin
      e.op = in_op; e.pc = in_address; e.imm = in_immediate; e.pred = in_pred_target;
      e.d1 = in_data_1; e.d2 = in_data_2; e.r1 = in_rdy_1; e.r2 = in_rdy_2;
      e.t1 = in_tag_1; e.t2 = in_tag_2; e.dst = in_dst_tag;
      if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1; e.d1 = cdb_data; end
      if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1; e.d2 = cdb_data; end
      stq.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    in_valid = 0;
    cdb_valid = 0;
    flush_in = 0;
  endtask

  task automatic offer(input logic [2:0] op, input logic [31:0] pc, imm, d1, d2,
                       input bit r1, r2, input logic [5:0] t1, t2, dst, input logic [31:0] pred);
    in_valid = 1; in_op = op; in_address = pc; in_immediate = imm;
    in_data_1 = d1; in_data_2 = d2; in_rdy_1 = r1; in_rdy_2 = r2;
    in_tag_1 = t1; in_tag_2 = t2; in_dst_tag = dst; in_pred_target = pred;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      default: return 32'($urandom_range(0, 15));
    endcase
  endfunction

  bit prev_hold = 0;
  logic [5:0] prev_tag = '0;
  logic [31:0] prev_data = '0;

  always @(negedge clock) begin
    if (mon_en) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, stq.size() < DEPTH});
      check("rb_req", {31'd0, rb_req}, {31'd0, m_full});
      check("redirect", {31'd0, redirect}, {31'd0, m_redirect});
      if (m_redirect) check("redirect_address", redirect_address, m_raddr);
      if (prev_hold) begin
        check("hold_tag", {26'd0, rb_tag}, {26'd0, prev_tag});
        check("hold_data", rb_data, prev_data);
      end
      if (rb_req && rb_grant) begin
        if (sb.size() == 0) begin
          chk_cnt++;
          $display("FAIL grant_pop: got a granted result, expected none outstanding");
        end else begin
          mon_r = sb.pop_front();
          check("rb_tag", {26'd0, rb_tag}, {26'd0, mon_r.tag});
          check("rb_data", rb_data, mon_r.data);
          check("rb_writes", {31'd0, rb_writes}, {31'd0, mon_r.writes});
        end
      end
      prev_hold = rb_req && !rb_grant && !flush_in && reset_n && m_full;
      prev_tag = rb_tag;
      prev_data = rb_data;
    end
  end

  initial begin
    reset_n = 0; flush_in = 0; in_valid = 0; rb_grant = 0; cdb_valid = 0;
    offer(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    in_valid = 0; cdb_tag = 0; cdb_data = 0;
    tick();
    tick();
    mon_en = 1;
    check("reset_rb_tag", {26'd0, rb_tag}, 32'd0);
    check("reset_rb_data", rb_data, 32'd0);
    check("reset_rb_writes", {31'd0, rb_writes}, 32'd0);
    check("reset_redirect_address", redirect_address, 32'd0);
    check("reset_ex_op", {29'd0, ex_op}, 32'd0);
    check("reset_ex_address", ex_address, 32'd0);
    reset_n = 1;

    // BEQ taken against a fall-through prediction
    rb_grant = 1;
    offer(2, 32'h100, 32'h20, 5, 5, 1, 1, 0, 0, 1, 32'h104); tick();
    repeat (4) tick();
    // JAL with correct prediction, link written
    offer(0, 32'h200, 32'hFFFF_FFF8, 0, 0, 1, 1, 0, 0, 9, 32'h1F8); tick();
    repeat (3) tick();
    // Older ready BNE goes first; BLT waits on tag 3
    offer(3, 32'h300, 32'h10, 1, 2, 1, 1, 0, 0, 4, 32'h310); tick();
    offer(4, 32'h340, 32'h40, 0, 1, 0, 1, 3, 0, 5, 32'h344); tick();
    repeat (2) tick();
    cdb_valid = 1; cdb_tag = 3; cdb_data = 32'hFFFF_FFFF; tick();
    repeat (4) tick();
    // Fill the station with the result bus stalled, then drain one grant at a time
    rb_grant = 0;
    for (int k = 0; k < 5; k++) begin
      offer(2, 32'h400 + 32'(16 * k), 32'h8, 32'(k), 32'(k), 1, 1, 0, 0, 6'(10 + k), 32'h408 + 32'(16 * k));
      tick();
    end
    repeat (3) tick();
    for (int k = 0; k < 5; k++) begin
      rb_grant = 1; tick();
      rb_grant = 0; tick();
    end
    // Allocation coincident with the broadcast of its tag
    rb_grant = 1;
    offer(2, 32'h500, 32'h30, 0, 7, 0, 1, 12, 0, 20, 32'h530);
    cdb_valid = 1; cdb_tag = 12; cdb_data = 7; tick();
    repeat (4) tick();
    // Flush with the slot full and three entries waiting
    rb_grant = 0;
    for (int k = 0; k < 4; k++) begin
      offer(2, 32'h600 + 32'(16 * k), 32'h8, 1, 1, 1, 1, 0, 0, 6'(30 + k), 32'h608 + 32'(16 * k));
      tick();
    end
    tick();
    flush_in = 1; tick();
    repeat (3) tick();
    // Reset in the middle of activity
    rb_grant = 1;
    offer(0, 32'h700, 32'h4, 0, 0, 1, 1, 0, 0, 2, 32'h704); tick();
    reset_n = 0; tick();
    reset_n = 1; tick();

    for (int n = 0; n < 800; n++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      in_op = 3'($urandom_range(0, 7));
      in_address = 32'($urandom_range(0, 16'h3FFF)) << 2;
      in_immediate = (32'($urandom_range(0, 63)) - 32'd32) << 2;
      in_data_1 = pick_val();
      in_data_2 = pick_val();
      in_rdy_1 = ($urandom_range(0, 99) < 65);
      in_rdy_2 = ($urandom_range(0, 99) < 65);
      in_tag_1 = 6'($urandom_range(0, 7));
      in_tag_2 = 6'($urandom_range(0, 7));
      in_dst_tag = 6'($urandom_range(0, 63));
      in_pred_target = ($urandom_range(0, 1) == 1) ? in_address + 32'd4 : in_address + in_immediate;
      cdb_valid = ($urandom_range(0, 99) < 40);
      cdb_tag = 6'($urandom_range(0, 7));
      cdb_data = pick_val();
      rb_grant = ($urandom_range(0, 99) < 70);
      flush_in = ($urandom_range(0, 99) < 2);
      tick();
    end

    rb_grant = 1;
    repeat (10) tick();
    flush_in = 1; tick();
    tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
